mtr_duty_ramp: RTL and testbench

//  Converts signed left/right motor speed requests into offset-binary 11-bit duty words for
//  the two PWM11 generators directly downstream. Duty changes are slew-limited by STEP per PWM

---
 rtl/mtr_duty_ramp.sv | 247 ++++++++++++++++++++++++
 tb/tb_mtr_duty_ramp.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mtr_duty_ramp.sv
`default_nettype none
// ============================================================================
// Module   : mtr_duty_ramp
// Purpose  : Turns signed left/right motor speed requests into offset-binary
//            11-bit duty words for two downstream PWM11 generators. New duty
//            values are applied only on the last cycle of each PWM period
//            (the "tick"), so a generator never sees a duty change part way
//            through its period. Targets are clamped to
//            [DUTY_MIN, DUTY_MAX]. An emergency stop forces both duties and
//            both targets to zero speed.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   MTR_RAMP_EN defined : each duty moves by at most STEP per tick.
//   MTR_RAMP_EN absent  : each duty loads its target on the next tick and
//                         STEP is unused.
// ----------------------------------------------------------------------------
// Parameters:
//   CNT_W     tick period = 2**CNT_W clk cycles (matches the PWM11 counter)
//   STEP      max duty change per tick, 1..1023
//   DUTY_MIN  lowest legal duty word
//   DUTY_MAX  highest legal duty word, DUTY_MIN < DUTY_MAX <= 2047
// Ports:
//   clk        in   1   clock
//   rst_n      in   1   asynchronous active-low reset
//   lft_spd    in   11  signed left speed request, -1024..1023
//   rght_spd   in   11  signed right speed request, -1024..1023
//   spd_vld    in   1   one-cycle strobe: capture both speeds as new targets
//   e_stop     in   1   level-sensitive emergency stop
//   lft_duty   out  11  registered left duty word
//   rght_duty  out  11  registered right duty word
//   tick       out  1   registered, high on the last cycle of each period
//   at_target  out  1   registered, high when both duties sit on their
//                       targets and no emergency stop is active
// ============================================================================
module mtr_duty_ramp #(
    parameter int CNT_W    = 11,
    parameter int STEP     = 8,
    parameter int DUTY_MIN = 32,
    parameter int DUTY_MAX = 2015
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    input  logic        spd_vld,
    input  logic        e_stop,
    output logic [10:0] lft_duty,
    output logic [10:0] rght_duty,
    output logic        tick,
    output logic        at_target
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [10:0]      c_DUTY_ZERO = 11'h400;
    localparam logic [10:0]      c_DUTY_MIN  = 11'(DUTY_MIN);
    localparam logic [10:0]      c_DUTY_MAX  = 11'(DUTY_MAX);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    // Counter value one cycle before the all-ones value: the registered tick
    // is launched here so that it is high while the counter reads all ones.
    localparam logic [CNT_W-1:0] c_CNT_PRE   = {{(CNT_W-1){1'b1}}, 1'b0};
`ifdef MTR_RAMP_EN
    localparam logic signed [11:0] c_STEP = 12'(STEP);
`endif

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------------
    if (CNT_W < 2) begin : g_chk_cnt_w
        $error("mtr_duty_ramp: CNT_W must be at least 2");
    end
    if (STEP < 1 || STEP > 1023) begin : g_chk_step
        $error("mtr_duty_ramp: STEP must be in 1..1023");
    end
    if (DUTY_MIN < 0 || DUTY_MIN >= DUTY_MAX || DUTY_MAX > 2047) begin : g_chk_duty
        $error("mtr_duty_ramp: need 0 <= DUTY_MIN < DUTY_MAX <= 2047");
    end

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_ESTOP = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             tick_q,      tick_d;
    logic [10:0]      lft_tgt_q,   lft_tgt_d;
    logic [10:0]      rght_tgt_q,  rght_tgt_d;
    logic [10:0]      lft_duty_q,  lft_duty_d;
    logic [10:0]      rght_duty_q, rght_duty_d;
    logic             at_target_q, at_target_d;

    // High when either next duty differs from its next target.
    logic             w_off_target;

    // ------------------------------------------------------------------------
    // Speed to duty target: adding 1024 to an 11-bit two's-complement value
    // is the same as inverting its MSB, which yields offset binary 0..2047.
    // ------------------------------------------------------------------------
    function automatic logic [10:0] map_target(input logic [10:0] spd);
        logic [10:0] raw;
        raw = {~spd[10], spd[9:0]};
        if (raw < c_DUTY_MIN) begin
            return c_DUTY_MIN;
        end else if (raw > c_DUTY_MAX) begin
            return c_DUTY_MAX;
        end else begin
            return raw;
        end
    endfunction

`ifdef MTR_RAMP_EN
    // ------------------------------------------------------------------------
    // One slew-limited step of duty toward tgt. The difference is taken in
    // 12-bit signed arithmetic so it can never wrap. Since tgt is always
    // within the clamp window and a full STEP is only taken when the
    // remaining distance exceeds STEP, the duty cannot overshoot the target
    // or leave the legal range.
    // ------------------------------------------------------------------------
    function automatic logic [10:0] step_toward(input logic [10:0] duty,
                                                input logic [10:0] tgt);
        logic signed [11:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, duty});
        if (diff > c_STEP) begin
            return duty + c_STEP[10:0];
        end else if (diff < -c_STEP) begin
            return duty - c_STEP[10:0];
        end else begin
            return tgt;
        end
    endfunction
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + c_CNT_ONE;
        tick_d       = (cnt_q == c_CNT_PRE);
        lft_tgt_d    = lft_tgt_q;
        rght_tgt_d   = rght_tgt_q;
        lft_duty_d   = lft_duty_q;
        rght_duty_d  = rght_duty_q;
        w_off_target = 1'b0;

        if (e_stop) begin
            // Stop wins over strobes and ticks: both channels snap to zero
            // speed right away and their targets are forgotten.
            lft_tgt_d   = c_DUTY_ZERO;
            rght_tgt_d  = c_DUTY_ZERO;
            lft_duty_d  = c_DUTY_ZERO;
            rght_duty_d = c_DUTY_ZERO;
            state_d     = ST_ESTOP;
        end else begin
            // Duties move from the targets held in the registers, so a strobe
            // landing on the tick cycle only takes effect at the next tick.
            if (tick_q) begin
`ifdef MTR_RAMP_EN
                lft_duty_d  = step_toward(lft_duty_q,  lft_tgt_q);
                rght_duty_d = step_toward(rght_duty_q, rght_tgt_q);
`else
                lft_duty_d  = lft_tgt_q;
                rght_duty_d = rght_tgt_q;
`endif
            end

            if (spd_vld) begin
                lft_tgt_d  = map_target(lft_spd);
                rght_tgt_d = map_target(rght_spd);
            end

            w_off_target = (lft_duty_d != lft_tgt_d) || (rght_duty_d != rght_tgt_d);

            unique case (state_q)
                ST_IDLE: begin
                    if (spd_vld && w_off_target) begin
                        state_d = ST_RAMP;
                    end
                end
                ST_RAMP: begin
                    // Leave only on a tick that lands both channels; a strobe
                    // on that same cycle with a fresh target keeps us ramping.
                    if (tick_q && !w_off_target) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ESTOP: begin
                    // Targets were parked at zero speed, so release normally
                    // returns to IDLE. A strobe on the release cycle itself
                    // is honoured and goes straight to RAMP if it moves a
                    // target, keeping at_target truthful.
                    state_d = (spd_vld && w_off_target) ? ST_RAMP : ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        at_target_d = (state_d == ST_IDLE);
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tick_q      <= 1'b0;
            lft_tgt_q   <= c_DUTY_ZERO;
            rght_tgt_q  <= c_DUTY_ZERO;
            lft_duty_q  <= c_DUTY_ZERO;
            rght_duty_q <= c_DUTY_ZERO;
            at_target_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            lft_tgt_q   <= lft_tgt_d;
            rght_tgt_q  <= rght_tgt_d;
            lft_duty_q  <= lft_duty_d;
            rght_duty_q <= rght_duty_d;
            at_target_q <= at_target_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign lft_duty  = lft_duty_q;
    assign rght_duty = rght_duty_q;
    assign tick      = tick_q;
    assign at_target = at_target_q;

endmodule
`default_nettype wire

// File: tb/tb_mtr_duty_ramp.sv
`default_nettype none
// ============================================================================
// Module   : tb_mtr_duty_ramp
// Purpose  : Directed self-checking bench for mtr_duty_ramp. Inputs change
//            on the falling clock edge, outputs are sampled on the falling
//            edge. Expected values are hand-derived constants. Sections under
//            MTR_RAMP_EN exercise the slew-limited build, the others the
//            direct-load build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mtr_duty_ramp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] lft_spd;
    logic [10:0] rght_spd;
    logic        spd_vld;
    logic        e_stop;
    logic [10:0] lft_duty;
    logic [10:0] rght_duty;
    logic        tick;
    logic        at_target;

    int n_checks = 0;
    int n_errors = 0;

`ifdef MTR_RAMP_EN
    localparam logic [10:0] c_EXP_RST_MID = 11'h408;
`else
    localparam logic [10:0] c_EXP_RST_MID = 11'h52C;
`endif

    mtr_duty_ramp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lft_spd   (lft_spd),
        .rght_spd  (rght_spd),
        .spd_vld   (spd_vld),
        .e_stop    (e_stop),
        .lft_duty  (lft_duty),
        .rght_duty (rght_duty),
        .tick      (tick),
        .at_target (at_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance to the next falling edge on which tick is high (bounded).
    task automatic wait_tick();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 2100 && !found; k++) begin
            @(negedge clk);
            if (tick === 1'b1) found = 1'b1;
        end
        check("tick_seen", {31'd0, found}, 32'd1);
    endtask

    // One-cycle speed strobe; returns on the following falling edge.
    task automatic strobe(input int l, input int r);
        lft_spd  = 11'(l);
        rght_spd = 11'(r);
        spd_vld  = 1'b1;
        @(negedge clk);
        spd_vld  = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        lft_spd  = '0;
        rght_spd = '0;
        spd_vld  = 1'b0;
        e_stop   = 1'b0;

        // ---------------- reset state ----------------
        cyc(2);
        check("rst_lft_duty",  32'(lft_duty),  32'h400);
        check("rst_rght_duty", 32'(rght_duty), 32'h400);
        check("rst_tick",      32'(tick),      32'd0);
        check("rst_at_target", 32'(at_target), 32'd1);

        // ---------------- tick timing ----------------
        rst_n = 1'b1;
        cyc(2046);
        check("tick_before_first", 32'(tick), 32'd0);
        cyc(1);
        check("tick_first_2047", 32'(tick), 32'd1);
        cyc(1);
        check("tick_after_first", 32'(tick), 32'd0);
        cyc(2046);
        check("tick_before_second", 32'(tick), 32'd0);
        cyc(1);
        check("tick_second_4095", 32'(tick), 32'd1);

`ifdef MTR_RAMP_EN
        // ---------------- +100 ramp, strobe on the tick cycle ----------------
        strobe(100, 0);
        check("ramp_old_tgt_lft", 32'(lft_duty),  32'h400);
        check("ramp_busy",        32'(at_target), 32'd0);
        for (int i = 1; i <= 13; i++) begin
            wait_tick();
            cyc(1);
            check("ramp_up_lft",  32'(lft_duty),  (i < 13) ? 32'h400 + 32'(8 * i) : 32'h464);
            check("ramp_up_rght", 32'(rght_duty), 32'h400);
            check("ramp_up_at",   32'(at_target), (i < 13) ? 32'd0 : 32'd1);
        end

        // ---------------- reverse to -16 (target 0x3F0) ----------------
        strobe(-16, 0);
        check("rev_busy", 32'(at_target), 32'd0);
        for (int i = 1; i <= 15; i++) begin
            wait_tick();
            cyc(1);
            check("ramp_dn_lft", 32'(lft_duty), (i < 15) ? 32'h464 - 32'(8 * i) : 32'h3F0);
        end
        check("rev_done_at", 32'(at_target), 32'd1);

        // ---------------- clamped extremes, first steps ----------------
        strobe(1023, -1024);
        for (int i = 1; i <= 3; i++) begin
            wait_tick();
            cyc(1);
            check("clamp_lft_step",  32'(lft_duty),  32'h3F0 + 32'(8 * i));
            check("clamp_rght_step", 32'(rght_duty), 32'h400 - 32'(8 * i));
        end
        check("clamp_busy", 32'(at_target), 32'd0);
`else
        // ---------------- strobe on tick, direct load at next tick ----------------
        strobe(500, -300);
        check("direct_old_tgt_lft", 32'(lft_duty),  32'h400);
        check("direct_busy",        32'(at_target), 32'd0);
        wait_tick();
        check("direct_hold_lft", 32'(lft_duty), 32'h400);
        cyc(1);
        check("direct_lft",  32'(lft_duty),  32'h5F4);
        check("direct_rght", 32'(rght_duty), 32'h2D4);
        check("direct_at",   32'(at_target), 32'd1);

        // ---------------- clamping at both extremes ----------------
        strobe(1023, -1024);
        wait_tick();
        cyc(1);
        check("clamp_hi_lft",  32'(lft_duty),  32'h7DF);
        check("clamp_lo_rght", 32'(rght_duty), 32'h020);
        check("clamp_at",      32'(at_target), 32'd1);

        // ---------------- small negative / positive speeds ----------------
        strobe(-16, 5);
        wait_tick();
        cyc(1);
        check("neg16_lft", 32'(lft_duty),  32'h3F0);
        check("pos5_rght", 32'(rght_duty), 32'h405);
`endif

        // ---------------- emergency stop ----------------
        strobe(100, 0);
        check("pre_estop_busy", 32'(at_target), 32'd0);
        e_stop = 1'b1;
        cyc(1);
        check("estop_lft",  32'(lft_duty),  32'h400);
        check("estop_rght", 32'(rght_duty), 32'h400);
        check("estop_at",   32'(at_target), 32'd0);
        strobe(200, 50);
        check("estop_vld_lft", 32'(lft_duty),  32'h400);
        check("estop_vld_at",  32'(at_target), 32'd0);
        wait_tick();
        cyc(1);
        check("estop_tick_lft",  32'(lft_duty),  32'h400);
        check("estop_tick_rght", 32'(rght_duty), 32'h400);
        e_stop = 1'b0;
        cyc(1);
        check("release_at", 32'(at_target), 32'd1);
        wait_tick();
        cyc(1);
        check("release_tick_lft",  32'(lft_duty),  32'h400);
        check("release_tick_rght", 32'(rght_duty), 32'h400);
        check("release_tick_at",   32'(at_target), 32'd1);

        // ---------------- asynchronous reset after a move ----------------
        strobe(300, 0);
        wait_tick();
        cyc(1);
        check("pre_rst_lft", 32'(lft_duty), 32'(c_EXP_RST_MID));
        rst_n = 1'b0;
        #1;
        check("async_rst_lft",  32'(lft_duty),  32'h400);
        check("async_rst_rght", 32'(rght_duty), 32'h400);
        check("async_rst_at",   32'(at_target), 32'd1);
        check("async_rst_tick", 32'(tick),      32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
